// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port (fetch/data) arbiter onto one fixed-latency memory port.
// Optional round-robin arbitration under `MEMORY_ARBITER_RR_EN; default build grants data first.
module memory_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    localparam int LAT_I = (MEM_LATENCY >= 1 && MEM_LATENCY <= 7) ? MEM_LATENCY : 1;
    localparam logic [2:0] LAT = 3'(LAT_I);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic        is_store_q, is_store_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_d, grant_if;

`ifdef MEMORY_ARBITER_RR_EN
    // Set when data should win the next tie; flips toward the port not served last.
    logic        rr_prefer_d_q, rr_prefer_d_d;

    always_comb begin
        if (d_req && if_req) begin
            grant_d = rr_prefer_d_q;
        end else begin
            grant_d = d_req;
        end
        grant_if = if_req & ~grant_d;
    end
`else
    always_comb begin
        grant_d  = d_req;
        grant_if = if_req & ~d_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        is_store_d  = is_store_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEMORY_ARBITER_RR_EN
        rr_prefer_d_d = rr_prefer_d_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    state_d     = S_D_BUSY;
                    cnt_d       = LAT;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_re_d    = ~d_we;
                    mem_we_d    = d_we;
                    is_store_d  = d_we;
`ifdef MEMORY_ARBITER_RR_EN
                    rr_prefer_d_d = 1'b0;
`endif
                end else if (grant_if) begin
                    state_d     = S_IF_BUSY;
                    cnt_d       = LAT;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'h0;
                    mem_re_d    = 1'b1;
                    is_store_d  = 1'b0;
`ifdef MEMORY_ARBITER_RR_EN
                    rr_prefer_d_d = 1'b1;
`endif
                end
            end
            S_IF_BUSY, S_D_BUSY: begin
                // A zero count can only come from corruption; retire rather than wrap.
                if (cnt_q <= 3'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == S_IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!is_store_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            is_store_q  <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
`ifdef MEMORY_ARBITER_RR_EN
            rr_prefer_d_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            is_store_q  <= is_store_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEMORY_ARBITER_RR_EN
            rr_prefer_d_q <= rr_prefer_d_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter (latency 2 and 1).
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_valid, d_valid, mem_re, mem_we, stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    logic        if_req1, d_req1, d_we1;
    logic [31:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
    logic        if_valid1, d_valid1, mem_re1, mem_we1, stall1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.MEM_LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    memory_arbiter #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_valid(if_valid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_valid(d_valid1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .stall(stall1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    int n_grants;
    logic [3:0] grant_is_d;
    logic [3:0] exp_seq;

    initial begin
        mem_rdata = 0;
        if_req1 = 0; d_req1 = 0; d_we1 = 0;
        if_addr1 = 32'h0000_0100; d_addr1 = 0; d_wdata1 = 0; mem_rdata1 = 0;
        do_reset();

        check_eq("rst_mem_re",   {31'b0, mem_re},   32'h0);
        check_eq("rst_mem_we",   {31'b0, mem_we},   32'h0);
        check_eq("rst_mem_addr", mem_addr,          32'h0);
        check_eq("rst_mem_wdat", mem_wdata,         32'h0);
        check_eq("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check_eq("rst_d_valid",  {31'b0, d_valid},  32'h0);
        check_eq("rst_if_rdata", if_rdata,          32'h0);
        check_eq("rst_d_rdata",  d_rdata,           32'h0);
        check_eq("rst_stall",    {31'b0, stall},    32'h0);

        // Fetch at latency 2
        if_req = 1; if_addr = 32'h0040_0000;
        #1;
        check_eq("f_stall_req", {31'b0, stall}, 32'h1);
        tick();
        check_eq("f_mem_re_N",  {31'b0, mem_re}, 32'h1);
        check_eq("f_mem_we_N",  {31'b0, mem_we}, 32'h0);
        check_eq("f_mem_addr",  mem_addr, 32'h0040_0000);
        mem_rdata = 32'h2008_0005;
        tick();
        check_eq("f_mem_re_N1", {31'b0, mem_re}, 32'h0);
        check_eq("f_valid_N1",  {31'b0, if_valid}, 32'h0);
        check_eq("f_stall_N1",  {31'b0, stall}, 32'h1);
        check_eq("f_addr_hold", mem_addr, 32'h0040_0000);
        tick();
        check_eq("f_valid_N2",  {31'b0, if_valid}, 32'h1);
        check_eq("f_rdata_N2",  if_rdata, 32'h2008_0005);
        check_eq("f_stall_N2",  {31'b0, stall}, 32'h0);
        if_req = 0;
        tick();
        check_eq("f_valid_N3",  {31'b0, if_valid}, 32'h0);
        check_eq("f_stall_N3",  {31'b0, stall}, 32'h0);
        check_eq("f_rdata_hold", if_rdata, 32'h2008_0005);

        // Store at latency 2: d_rdata must stay untouched
        d_req = 1; d_we = 1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h1111_1111;
        tick();
        check_eq("s_mem_we_N",  {31'b0, mem_we}, 32'h1);
        check_eq("s_mem_re_N",  {31'b0, mem_re}, 32'h0);
        check_eq("s_mem_addr",  mem_addr, 32'h1001_0004);
        check_eq("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check_eq("s_mem_we_N1", {31'b0, mem_we}, 32'h0);
        check_eq("s_valid_N1",  {31'b0, d_valid}, 32'h0);
        tick();
        check_eq("s_valid_N2",  {31'b0, d_valid}, 32'h1);
        check_eq("s_rdata_keep", d_rdata, 32'h0);
        check_eq("s_if_valid",  {31'b0, if_valid}, 32'h0);
        d_req = 0; d_we = 0;
        tick();
        check_eq("s_valid_N3",  {31'b0, d_valid}, 32'h0);

        // Simultaneous load and fetch: data first, fetch strobes at N+3
        do_reset();
        d_req = 1; d_addr = 32'h1001_0008; if_req = 1; if_addr = 32'h0040_0004;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        check_eq("p_re_N",      {31'b0, mem_re}, 32'h1);
        check_eq("p_addr_N",    mem_addr, 32'h1001_0008);
        tick();
        tick();
        check_eq("p_dvalid_N2", {31'b0, d_valid}, 32'h1);
        check_eq("p_drdata_N2", d_rdata, 32'hCAFE_F00D);
        check_eq("p_stall_N2",  {31'b0, stall}, 32'h1);
        d_req = 0;
        mem_rdata = 32'h0BAD_C0DE;
        tick();
        check_eq("p_re_N3",     {31'b0, mem_re}, 32'h1);
        check_eq("p_addr_N3",   mem_addr, 32'h0040_0004);
        tick();
        check_eq("p_ivalid_N4", {31'b0, if_valid}, 32'h0);
        tick();
        check_eq("p_ivalid_N5", {31'b0, if_valid}, 32'h1);
        check_eq("p_irdata_N5", if_rdata, 32'h0BAD_C0DE);
        check_eq("p_drdata_kp", d_rdata, 32'hCAFE_F00D);
        if_req = 0;
        tick();

        // Both ports held continuously: grant order over four accesses
        do_reset();
        d_req = 1; d_addr = 32'h1001_0020; if_req = 1; if_addr = 32'h0040_0020;
        n_grants = 0;
        grant_is_d = 4'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem_re && n_grants < 4) begin
                grant_is_d[n_grants] = (mem_addr == 32'h1001_0020);
                n_grants++;
            end
        end
`ifdef MEMORY_ARBITER_RR_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        check_eq("c_grant_cnt", 32'(n_grants), 32'd4);
        check_eq("c_grant_seq", {28'b0, grant_is_d}, {28'b0, exp_seq});
        d_req = 0; if_req = 0;

        // Reset one cycle after a load grant aborts it; held request is regranted
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h1001_0010;
        mem_rdata = 32'h5555_AAAA;
        tick();
        check_eq("r_re_N",      {31'b0, mem_re}, 32'h1);
        reset = 1;
        tick();
        reset = 0;
        check_eq("r_re_N1",     {31'b0, mem_re}, 32'h0);
        check_eq("r_addr_N1",   mem_addr, 32'h0);
        check_eq("r_dvalid_N1", {31'b0, d_valid}, 32'h0);
        check_eq("r_drdata_N1", d_rdata, 32'h0);
        tick();
        check_eq("r_re_N2",     {31'b0, mem_re}, 32'h1);
        check_eq("r_addr_N2",   mem_addr, 32'h1001_0010);
        check_eq("r_dvalid_N2", {31'b0, d_valid}, 32'h0);
        tick();
        check_eq("r_dvalid_N3", {31'b0, d_valid}, 32'h0);
        tick();
        check_eq("r_dvalid_N4", {31'b0, d_valid}, 32'h1);
        check_eq("r_drdata_N4", d_rdata, 32'h5555_AAAA);
        d_req = 0;
        tick();

        // Request dropped after grant still completes with a valid pulse
        d_req = 1; d_addr = 32'h1001_0030; mem_rdata = 32'h0000_0077;
        tick();
        check_eq("x_re_N",      {31'b0, mem_re}, 32'h1);
        d_req = 0;
        tick();
        check_eq("x_stall_N1",  {31'b0, stall}, 32'h0);
        tick();
        check_eq("x_dvalid_N2", {31'b0, d_valid}, 32'h1);
        check_eq("x_drdata_N2", d_rdata, 32'h0000_0077);
        tick();

        // Latency 1, continuous fetch: valid every other cycle
        do_reset();
        if_req1 = 1; mem_rdata1 = 32'h1357_2468;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq($sformatf("l1_re_%0d", i),    {31'b0, mem_re1},    32'(i % 2));
            check_eq($sformatf("l1_valid_%0d", i), {31'b0, if_valid1},  32'((i + 1) % 2));
            check_eq($sformatf("l1_stall_%0d", i), {31'b0, stall1},     32'(i % 2));
        end
        check_eq("l1_rdata",   if_rdata1, 32'h1357_2468);
        check_eq("l1_dvalid",  {31'b0, d_valid1}, 32'h0);
        check_eq("l1_drdata",  d_rdata1, 32'h0);
        check_eq("l1_we",      {31'b0, mem_we1}, 32'h0);
        check_eq("l1_addr",    mem_addr1, 32'h0000_0100);
        check_eq("l1_wdata",   mem_wdata1, 32'h0);
        if_req1 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning cycles from memory strobe to mem_rdata valid (legal 1..7).
REQ-002 SHALL have port clk  input  1  single processor clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_valid.
REQ-005 SHALL have port if_addr  input  32  fetch byte address, stable while if_req high.
REQ-006 SHALL have port if_valid  output  1  one-cycle pulse: fetch complete.
REQ-007 SHALL have port if_rdata  output  32  fetched instruction.
REQ-008 SHALL have port d_req  input  1  data request, held until d_valid.
REQ-009 SHALL have port d_we  input  1  1 = store, 0 = load; stable while d_req high.
REQ-010 SHALL have port d_addr  input  32  data byte address.
REQ-011 SHALL have port d_wdata  input  32  store data.
REQ-012 SHALL have port d_valid  output  1  one-cycle pulse: data access complete.
REQ-013 SHALL have port d_rdata  output  32  load data.
REQ-014 SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_re  output  1, mem_we  output  1  shared memory side.
REQ-015 SHALL have port mem_rdata  input  32  shared memory read data.
REQ-016 SHALL have port stall  output  1  freezes PC/pipeline while any request is outstanding.

Function
REQ-017 SHALL implement FSM states IDLE, IF_BUSY, D_BUSY plus a 3-bit latency counter.
REQ-018 In IDLE with any request, SHALL grant that cycle, load counter with MEM_LATENCY, and enter IF_BUSY or D_BUSY.
REQ-019 On grant, SHALL drive mem_addr/mem_wdata from the winner and pulse mem_re (load/fetch) or mem_we (store) for exactly one cycle.
REQ-020 mem_addr and mem_wdata SHALL be registered at grant and held stable until return to IDLE.
REQ-021 In a BUSY state SHALL decrement counter each cycle; at counter==1 SHALL capture mem_rdata into if_rdata/d_rdata (reads only), pulse matching valid next cycle, and return to IDLE.
REQ-022 Latency: grant cycle N, valid in cycle N+MEM_LATENCY; back-to-back throughput one access per MEM_LATENCY+1 cycles.
REQ-023 Stores SHALL follow identical timing; d_rdata SHALL NOT change on a store.
REQ-024 Fixed priority: simultaneous if_req and d_req in IDLE SHALL grant d_req.
REQ-025 Requests arriving while BUSY SHALL wait; no preemption of an in-flight access.
REQ-026 if_rdata/d_rdata SHALL hold last captured value until their next read completion.
REQ-027 stall SHALL equal (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
REQ-028 A request dropped before its valid SHALL still complete in memory; its valid pulse SHALL still be issued.
REQ-029 MEM_LATENCY outside 1..7 SHALL be treated as 1.

Reset
REQ-030 Reset SHALL force state IDLE, counter 0, mem_re=mem_we=0, mem_addr=mem_wdata=0, if_valid=d_valid=0, if_rdata=d_rdata=0, round-robin pointer to data.
REQ-031 Reset mid-access SHALL abort it with no valid pulse; still-held requests SHALL be re-arbitrated in the first cycle after reset deasserts.

Configuration
REQ-032 With macro MEMORY_ARBITER_RR_EN defined, SHALL replace REQ-024 with round-robin: on simultaneous requests grant the port not granted last; pointer updates on every grant.
REQ-033 Without MEMORY_ARBITER_RR_EN, fixed data priority of REQ-024 SHALL apply and no pointer register SHALL exist.

Verification
REQ-034 MEM_LATENCY=2, if_req with if_addr=0x00400000, mem_rdata=0x20080005 -> mem_re pulse cycle N, if_valid and if_rdata=0x20080005 at N+2, stall low N+3.
REQ-035 d_req store d_addr=0x10010004 d_wdata=0xDEADBEEF -> single mem_we pulse with those values, d_valid at N+2, d_rdata unchanged.
REQ-036 if_req and d_req same cycle, macro off -> data granted first, fetch granted at N+3, if_valid N+5; macro on, repeat twice -> grants alternate D, IF, D, IF.
REQ-037 Assert reset one cycle after a load grant -> no d_valid, all outputs zero; d_req still high -> regranted the cycle after reset falls.
REQ-038 MEM_LATENCY=1, continuous if_req -> if_valid every 2 cycles, stall high except on valid cycles.
